// File: rtl/red_band_pkg.sv
// red_band_pkg
// Shared types and constants for the red band centroid detector.
// Holds the FSM state enum and the frame, accumulator and counter widths.
package red_band_pkg;

    localparam int FRAME_W = 320;
    localparam int FRAME_H = 240;
    localparam int SUM_W   = 22;
    localparam int CNT_W   = 14;
    localparam int ADDR_W  = 17;
    localparam int COL_W   = 9;
    localparam int ROW_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DIVIDE,
        ST_UPDATE
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider
// Unsigned restoring divider that produces one quotient bit per cycle.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   i_start       : one-cycle pulse that latches the operands
//   i_dividend    : DVD_W-bit dividend
//   i_divisor     : DVS_W-bit divisor (must be non-zero)
//   o_done        : one-cycle pulse when quotient/remainder are final
//   o_quotient    : DVD_W-bit quotient
//   o_remainder   : DVS_W-bit remainder
module seq_divider #(
    parameter int DVD_W = 22,
    parameter int DVS_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quotient,
    output logic [DVS_W-1:0] o_remainder
);

    localparam int STEP_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0]  r_rem;
    logic [DVD_W-1:0]  r_dvd;
    logic [DVS_W-1:0]  r_dvs;
    logic [DVD_W-1:0]  r_quot;
    logic [STEP_W-1:0] r_count;
    logic              r_busy;
    logic              r_done;

    logic [DVS_W-1:0]  w_remIn;
    logic [DVD_W-1:0]  w_dvdIn;
    logic [DVS_W-1:0]  w_dvsIn;
    logic [DVD_W-1:0]  w_quotIn;
    logic [DVS_W:0]    w_shift;
    logic [DVS_W+1:0]  w_diff;
    logic              w_qBit;
    logic [DVS_W-1:0]  w_remNext;
    logic              w_unusedBit;

    // The start cycle already performs the first step on the raw operands,
    // so the final quotient is ready DVD_W cycles after i_start.
    assign w_remIn   = i_start ? '0 : r_rem;
    assign w_dvdIn   = i_start ? i_dividend : r_dvd;
    assign w_dvsIn   = i_start ? i_divisor : r_dvs;
    assign w_quotIn  = i_start ? '0 : r_quot;

    // The partial remainder is always below the divisor, so the shifted
    // value fits in DVS_W+1 bits; the extra top bit of the difference is
    // the borrow that says the trial subtraction failed.
    assign w_shift     = {w_remIn, w_dvdIn[DVD_W-1]};
    assign w_diff      = {1'b0, w_shift} - {2'b00, w_dvsIn};
    assign w_qBit      = ~w_diff[DVS_W+1];
    assign w_remNext   = w_qBit ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
    assign w_unusedBit = w_diff[DVS_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quot  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start || r_busy) begin
                r_rem  <= w_remNext;
                r_dvd  <= w_dvdIn << 1;
                r_dvs  <= w_dvsIn;
                r_quot <= {w_quotIn[DVD_W-2:0], w_qBit};
            end
            if (i_start) begin
                r_busy  <= 1'b1;
                r_count <= STEP_W'(1);
            end else if (r_busy) begin
                if (r_count == STEP_W'(DVD_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                r_count <= r_count + STEP_W'(1);
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule

// File: rtl/red_band_centroid.sv
// red_band_centroid
// Scans a horizontal band of the 320x240 RGB565 frame buffer once per
// camera frame (reads only while DE is low), counts red pixels, divides the
// column sum by the count and reports the mirrored centroid.
// Ports:
//   clk, reset      : 25 MHz clock, synchronous active-high reset
//   vsync           : raw camera vsync (asynchronous)
//   DE              : VGA data enable, reads allowed only while low
//   frame_data      : RGB565 read data, one cycle after its address
//   frame_addr      : frame buffer read address
//   scanning        : high while the band is still being read
//   player_x        : mirrored centroid, 0..319
//   player_detected : last completed frame had enough red pixels
//   result_valid    : one-cycle pulse when the outputs update
// Build option: define RED_SMOOTH_EN to average each new detection with the
// previous player_x.
module red_band_centroid
    import red_band_pkg::*;
#(
    parameter int BAND_Y0   = 180,
    parameter int BAND_H    = 32,
    parameter int R_MIN     = 20,
    parameter int G_MAX     = 24,
    parameter int B_MAX     = 12,
    parameter int MIN_COUNT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        DE,
    input  logic [15:0] frame_data,
    output logic [16:0] frame_addr,
    output logic        scanning,
    output logic [8:0]  player_x,
    output logic        player_detected,
    output logic        result_valid
);

    localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(BAND_Y0 * FRAME_W);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(FRAME_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(BAND_H - 1);
    localparam logic [4:0]        R_MIN_C    = 5'(R_MIN);
    localparam logic [5:0]        G_MAX_C    = 6'(G_MAX);
    localparam logic [4:0]        B_MAX_C    = 5'(B_MAX);
    localparam logic [CNT_W-1:0]  MIN_CNT_C  = CNT_W'(MIN_COUNT);
    localparam logic [COL_W-1:0]  RESET_X    = COL_W'(FRAME_W / 2);

    logic              r_vsyncMeta;
    logic              r_vsyncSync;
    logic              r_vsyncPrev;
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_issue;
    logic [COL_W-1:0]  r_issueCol;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_scanning;
    logic [COL_W-1:0]  r_playerX;
    logic              r_detected;
    logic              r_resultValid;

    logic              w_vsyncRise;
    logic              w_issue;
    logic              w_lastPixel;
    logic              w_isRed;
    logic              w_hit;
    logic [SUM_W-1:0]  w_sumNext;
    logic [CNT_W-1:0]  w_cntNext;
    logic              w_enough;
    logic              w_divStart;
    logic              w_divDone;
    logic [SUM_W-1:0]  w_quot;
    logic [CNT_W-1:0]  w_rem;
    logic [COL_W-1:0]  w_newX;
    logic [COL_W-1:0]  w_detX;
    logic              w_unusedDiv;

    // Two-stage synchronizer plus a previous-value register for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsyncMeta <= 1'b0;
            r_vsyncSync <= 1'b0;
            r_vsyncPrev <= 1'b0;
        end else begin
            r_vsyncMeta <= vsync;
            r_vsyncSync <= r_vsyncMeta;
            r_vsyncPrev <= r_vsyncSync;
        end
    end

    assign w_vsyncRise = r_vsyncSync & ~r_vsyncPrev;
    assign w_issue     = (r_state == ST_SCAN) && !DE;
    assign w_lastPixel = (r_row == LAST_ROW) && (r_col == LAST_COL);

    // The beat on frame_data belongs to the address issued last cycle, so
    // the red test is qualified with the registered issue flag.
    assign w_isRed   = (frame_data[15:11] >= R_MIN_C) &&
                       (frame_data[10:5]  <  G_MAX_C) &&
                       (frame_data[4:0]   <  B_MAX_C);
    assign w_hit     = r_issue && w_isRed;
    assign w_sumNext = w_hit ? r_sum + SUM_W'(r_issueCol) : r_sum;
    assign w_cntNext = w_hit ? r_cnt + CNT_W'(1) : r_cnt;

    // DRAIN decides on the totals including the final in-flight beat, and
    // the divider latches those same totals in that cycle.
    assign w_enough   = w_cntNext >= MIN_CNT_C;
    assign w_divStart = (r_state == ST_DRAIN) && w_enough;

    seq_divider #(
        .DVD_W (SUM_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_divStart),
        .i_dividend  (w_sumNext),
        .i_divisor   (w_cntNext),
        .o_done      (w_divDone),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    // The quotient never exceeds 319, so only its low 9 bits matter.
    assign w_newX      = LAST_COL - w_quot[COL_W-1:0];
    assign w_unusedDiv = ^{w_quot[SUM_W-1:COL_W], w_rem};

`ifdef RED_SMOOTH_EN
    logic             r_havePrev;
    logic [COL_W:0]   w_avg;
    logic             w_unusedAvg;

    assign w_avg       = ({1'b0, r_playerX} + {1'b0, w_newX} + (COL_W+1)'(1)) >> 1;
    assign w_detX      = r_havePrev ? w_avg[COL_W-1:0] : w_newX;
    assign w_unusedAvg = w_avg[COL_W];

    // History is valid only across consecutive detected frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_havePrev <= 1'b0;
        end else if ((r_state == ST_DIVIDE) && w_divDone) begin
            r_havePrev <= 1'b1;
        end else if ((r_state == ST_DRAIN) && !w_enough) begin
            r_havePrev <= 1'b0;
        end
    end
`else
    assign w_detX = w_newX;
`endif

    // Main FSM: scan address generation, accumulation and result update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_issue       <= 1'b0;
            r_issueCol    <= '0;
            r_sum         <= '0;
            r_cnt         <= '0;
            r_scanning    <= 1'b0;
            r_playerX     <= RESET_X;
            r_detected    <= 1'b0;
            r_resultValid <= 1'b0;
        end else begin
            r_issue       <= w_issue;
            r_issueCol    <= r_col;
            r_sum         <= w_sumNext;
            r_cnt         <= w_cntNext;
            r_resultValid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_vsyncRise) begin
                        r_state    <= ST_SCAN;
                        r_addr     <= BASE_ADDR;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_sum      <= '0;
                        r_cnt      <= '0;
                        r_scanning <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!DE) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        if (w_lastPixel) begin
                            r_state    <= ST_DRAIN;
                            r_scanning <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_enough) begin
                        r_state <= ST_DIVIDE;
                    end else begin
                        r_state       <= ST_UPDATE;
                        r_detected    <= 1'b0;
                        r_resultValid <= 1'b1;
                    end
                end
                ST_DIVIDE: begin
                    if (w_divDone) begin
                        r_state       <= ST_UPDATE;
                        r_playerX     <= w_detX;
                        r_detected    <= 1'b1;
                        r_resultValid <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_addr      = r_addr;
    assign scanning        = r_scanning;
    assign player_x        = r_playerX;
    assign player_detected = r_detected;
    assign result_valid    = r_resultValid;

endmodule

// File: doc/red_band_centroid.md
# red_band_centroid

Finds the player's horizontal position in each captured frame. On every camera frame it scans a fixed horizontal band of the 320x240 RGB565 frame buffer, reading only during VGA blanking, and classifies each pixel as red or not. It then divides the accumulated x-sum by the red-pixel count to get the centroid. It sits between the frame-buffer read port and the game controller, and produces the mirrored `player_x` / `player_detected` pair the controller consumes.

## Interface
- `BAND_Y0`, 180: first scanned row (0..239).
- `BAND_H`, 32: number of scanned rows; `BAND_Y0+BAND_H` ≤ 240.
- `R_MIN`, 20: red pixel requires R5 ≥ R_MIN.
- `G_MAX`, 24: red pixel requires G6 < G_MAX.
- `B_MAX`, 12: red pixel requires B5 < B_MAX.
- `MIN_COUNT`, 64: minimum red pixels for detection.

Ports:
- `clk` in 1: 25 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `vsync` in 1: raw camera vsync; asynchronous, synchronized internally.
- `DE` in 1: VGA data-enable; reads are legal only while low.
- `frame_data` in 16: RGB565 read data, valid 1 cycle after its address.
- `frame_addr` out 17: read address, meaningful while `scanning`=1 and `DE`=0.
- `scanning` out 1: high from scan start until the last read is issued.
- `player_x` out 9: mirrored centroid, 0..319.
- `player_detected` out 1: last completed frame met MIN_COUNT.
- `result_valid` out 1: one-cycle pulse when the outputs update.

## Operation
- vsync path: 2-FF synchronizer, then a rising-edge detect. A rising edge in IDLE starts a scan. Edges in any other state are ignored; a scan always completes.
- FSM states: IDLE → SCAN → DRAIN → DIVIDE → UPDATE → IDLE.
- SCAN:
  - On entry: addr = BAND_Y0·320, col = 0, row = 0, sum = 0, cnt = 0.
  - Each cycle with DE=0: issue addr, then addr+1, col+1. At col=319: col→0, row+1.
  - Cycles with DE=1: hold addr, col and row.
  - After issuing the last pixel (row=BAND_H−1, col=319), go to DRAIN and deassert `scanning`.
- Read pipeline:
  - An issue flag plus the issued col is registered for 1 cycle. A data beat is accepted only when the flag is set.
  - Red test on that beat: `frame_data[15:11]`≥R_MIN, `[10:5]`<G_MAX, `[4:0]`<B_MAX.
  - Red pixel: sum += col, cnt += 1.
- DRAIN: 1 cycle to absorb the final in-flight beat, then:
  - cnt ≥ MIN_COUNT → DIVIDE.
  - otherwise → UPDATE with detected=0.
- DIVIDE: unsigned restoring division of sum (22 b) by cnt (14 b), 1 quotient bit per cycle, 22 cycles. The quotient is ≤ 319 and is truncated to 9 b.
- UPDATE (1 cycle):
  - `player_x` = 319 − quotient, only when detected; otherwise it holds its previous value.
  - `player_detected` = detected.
  - Pulse `result_valid`.
- Widths: sum 22 b (max 10240·319 < 2²²), cnt 14 b. No overflow is possible for BAND_H ≤ 32; wider bands need wider accumulators, which is out of scope.

## Timing
- Reset values: `frame_addr`=0, `scanning`=0, `player_x`=160, `player_detected`=0, `result_valid`=0, FSM=IDLE, accumulators 0.
- Reset asserted mid-operation aborts immediately to the reset state. No result is produced for that frame.
- vsync edge to `scanning`=1: 3 cycles (2 synchronizer stages + edge register).
- Scan duration: BAND_H·320 cycles with DE=0, stretched by every DE=1 cycle.
- Last issue to `result_valid`: 24 cycles when dividing (DRAIN 1 + DIVIDE 22 + UPDATE 1), 2 cycles otherwise.
- Outputs are registered and stable between `result_valid` pulses.

## Configuration
- `RED_SMOOTH_EN` defined:
  - On a detected frame, `player_x` = (prev + new + 1) >> 1, computed in 10-bit arithmetic.
  - The first detection after reset, or after an undetected frame, loads `new` directly.
- Not defined: `player_x` = `new`, with no history register.

## Structure
- Package `red_band_pkg`:
  - FSM state enum.
  - Constants: FRAME_W=320, FRAME_H=240, SUM_W=22, CNT_W=14.
- Sub-module `seq_divider`: start/done handshake, parameterized dividend/divisor widths, restoring algorithm. It is reusable by other detectors.

## Test plan
- Band filled with red pixels at cols 100..119 (20·32=640 px), rest black → `result_valid` with `player_detected`=1, `player_x`=319−109=210.
- Only 63 red pixels in the band → `player_detected`=0, `player_x` holds its prior value.
- DE toggled at 640/160-cycle pattern during scan → `frame_addr` frozen while DE=1, no double counting, same result as the DE=0-only run.
- Second vsync edge mid-SCAN → ignored; exactly one `result_valid` for that scan.
- `reset` pulsed mid-DIVIDE → outputs return to reset values, no `result_valid`; the next vsync scans normally.
- `RED_SMOOTH_EN`: successive frames with centroids giving new=200 then new=100 → `player_x`=200, then 150.
